servant_spi_ram_ctrl: RTL and testbench
=======================================

Name: servant_spi_ram_ctrl

Overview:
SPI-slave front end that emulates a 23LC-style serial SRAM on top of the byte-wide servant SPI RAM array. It oversamples SCLK/CS_n/MOSI in the i_clk domain and decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address. It then sequences byte reads and writes into the RAM array, with sequential-mode auto-increment. It sits between the SoC's SPI master pins and the RAM model, so the CPU-side SPI memory path runs against a real serial-protocol target.

Parameters:
aw, 18, RAM byte-address width; the low aw bits of the 24-bit SPI address are used.

Ports:
i_clk  in  1  system clock; must be at least 6x SCLK frequency
i_rst  in  1  asynchronous, active-high reset
i_sclk  in  1  SPI clock, mode 0, asynchronous to i_clk
i_cs_n  in  1  SPI chip select, active low, asynchronous
i_mosi  in  1  SPI data in, MSB first
o_miso  out  1  SPI data out, MSB first
o_ram_addr  out  aw  RAM byte address
o_ram_wdata  out  8  RAM write byte
o_ram_we_n  out  1  RAM write strobe, active low, one i_clk cycle
o_ram_re  out  1  RAM read strobe, one i_clk cycle
i_ram_rdata  in  8  RAM read byte, combinational from o_ram_addr
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: o_miso=0, o_ram_addr=0, o_ram_wdata=0, o_ram_we_n=1, o_ram_re=0, o_busy=0.
- Reset state: IDLE, bit counter 0, shift registers 0.
- Synchronisers: two-flop on sclk, cs_n and mosi; all reset to sclk=0, cs_n=1, mosi=0.
- Edge detect: rise/fall pulses come from the synced sclk versus its registered copy.
- Transaction start: IDLE -> CMD only on a synced cs_n falling edge. After reset mid-transaction the block ignores traffic until cs_n goes high then low again.
- Abort: synced cs_n high in any state -> IDLE next cycle. The partial byte is discarded and o_miso=0. If cs_n-high and an sclk edge are detected in the same cycle, the abort wins and no RAM write is issued.
- Sampling: MOSI is sampled on sclk rise. A 3-bit counter counts bits per byte; the address phase uses a 5-bit counter (24 bits).
- CMD: collects 8 bits.
  - 0x02 -> ADDR with the write flag set.
  - 0x03 -> ADDR with the read flag clear.
  - Any other value -> IGNORE; o_miso stays 0 until cs_n rises.
- ADDR: collects 24 bits MSB first; bits [aw-1:0] load the address register and upper bits are dropped.
  - Read: in the cycle after the 24th rise, o_ram_re=1 for one cycle and i_ram_rdata is captured into the tx shift register; state -> RDATA.
  - Write: state -> WDATA.
- RDATA:
  - On each sclk fall, o_miso <= tx[7] and tx shifts left. The first fall after the 24th address rise drives bit 7 of byte 0.
  - On the 8th rise of each byte, the address increments. In the following cycle o_ram_re pulses and the new byte is captured, ready before the next fall.
- WDATA:
  - On the 8th rise, the assembled byte goes to o_ram_wdata.
  - In the next cycle, o_ram_we_n=0 for exactly one i_clk cycle with o_ram_addr stable.
  - In the cycle after the strobe, the address increments.
- Address wrap: the address increments modulo 2^aw, so 2^aw-1 -> 0 with no error.
- Strobes: o_ram_re and o_ram_we_n are never active in the same cycle, and are never active outside RDATA/WDATA setup.
- Latency: a RAM write occurs 2-3 i_clk cycles after the raw 8th sclk rise (synchroniser plus strobe cycle).

Test Plan:
- Write then read back: WRITE 0x02, addr 0x000010, data 0xA5 0x3C; then READ 0x03, addr 0x000010. Required: o_ram_we_n pulses once each at addr 0x10 and 0x11 with wdata 0xA5/0x3C; readback on MISO is 0xA5 then 0x3C.
- Wrap-around (aw=18): WRITE at addr 0x03FFFF, data 0x11 0x22. Required: writes land at 0x3FFFF and then 0x00000; a READ from 0x3FFFF returns 0x11 0x22.
- Abort mid-byte: WRITE, addr 0x20, 5 data bits, then cs_n high. Required: no o_ram_we_n pulse, o_busy=0 within 3 cycles, and a following READ of 0x20 returns the prior contents.
- Unknown command 0x9F followed by 32 clocks. Required: no RAM strobes, o_miso=0 throughout, IDLE after cs_n rises.
- Async reset asserted during RDATA of addr 0x40. Required: all outputs at reset values immediately. Clocks sent while cs_n is still low are ignored; a new cs_n low starts a correct READ.
- Upper address bits: READ with addr 0xFC0005. Required: o_ram_addr=0x00005.

Source files
------------

// File: rtl/servant_spi_ram_ctrl_if.sv
// Byte-wide RAM bus between the SPI SRAM front end and the RAM array.
//   o_ram_addr  : byte address (aw bits), driven by the controller
//   o_ram_wdata : write byte
//   o_ram_we_n  : write strobe, active low, one clock
//   o_ram_re    : read strobe, one clock
//   i_ram_rdata : read byte, combinational from o_ram_addr
// master = controller side, slave = RAM side.
interface servant_spi_ram_ctrl_if #(
    parameter int aw = 18
) ();
    logic [aw-1:0] o_ram_addr;
    logic [7:0]    o_ram_wdata;
    logic          o_ram_we_n;
    logic          o_ram_re;
    logic [7:0]    i_ram_rdata;

    modport master (
        output o_ram_addr, o_ram_wdata, o_ram_we_n, o_ram_re,
        input  i_ram_rdata
    );

    modport slave (
        input  o_ram_addr, o_ram_wdata, o_ram_we_n, o_ram_re,
        output i_ram_rdata
    );
endinterface

// File: rtl/servant_spi_ram_ctrl.sv
// SPI-slave (mode 0) front end emulating a 23LC-style serial SRAM on a
// byte-wide RAM array. SCLK/CS_n/MOSI are oversampled in i_clk (>= 6x SCLK).
// Supports READ (0x03) and WRITE (0x02) with a 24-bit address and sequential
// auto-increment; the low aw address bits are used.
//   i_clk, i_rst    : system clock, async active-high reset
//   i_sclk, i_cs_n, i_mosi, o_miso : SPI pins
//   o_busy          : high whenever the FSM is not IDLE
//   ram             : RAM bus (master modport)
module servant_spi_ram_ctrl #(
    parameter int aw = 18
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_busy,
    servant_spi_ram_ctrl_if.master ram
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

    state_t        state_q;
    logic          sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic          cs_s1_q, cs_s2_q, cs_prev_q;
    logic          mosi_s1_q, mosi_s2_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    logic [2:0]    bit_cnt_q;
    logic [4:0]    addr_cnt_q;
    logic [6:0]    rx_q;
    logic [7:0]    tx_q;
    logic [aw-2:0] addr_sh_q;
    logic          wr_q;
    logic [aw-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          we_n_q, re_q, miso_q;

    logic          rise, fall, cs_fall;
    logic [7:0]    rx_byte;
    logic [aw-1:0] addr_inc;

    always_comb begin
        rise     = sclk_s2_q & ~sclk_prev_q;
        fall     = ~sclk_s2_q & sclk_prev_q;
        cs_fall  = cs_prev_q & ~cs_s2_q;
        rx_byte  = {rx_q, mosi_s2_q};
        addr_inc = addr_q + {{(aw-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            addr_cnt_q  <= 5'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_sh_q   <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            re_q        <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_s1_q   <= i_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cs_s1_q     <= i_cs_n;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            mosi_s1_q   <= i_mosi;
            mosi_s2_q   <= mosi_s1_q;
            // The synchronisers power up showing cs_n high, so a pin held low
            // through reset would look like a falling edge. Only accept a
            // start after cs_n has genuinely been sampled high.
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_q | (fill_q[1] & cs_s2_q);

            re_q   <= 1'b0;
            we_n_q <= 1'b1;
            // Post-write increment, one cycle after the strobe.
            if (!we_n_q) addr_q <= addr_inc;

            // Abort has priority over any sclk edge seen in the same cycle.
            if (state_q != IDLE && cs_s2_q) begin
                state_q    <= IDLE;
                miso_q     <= 1'b0;
                bit_cnt_q  <= 3'd0;
                addr_cnt_q <= 5'd0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (armed_q && cs_fall) begin
                            state_q    <= CMD;
                            bit_cnt_q  <= 3'd0;
                            addr_cnt_q <= 5'd0;
                        end
                    end
                    CMD: if (rise) begin
                        rx_q      <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte == 8'h02) begin
                                wr_q <= 1'b1; state_q <= ADDR;
                            end else if (rx_byte == 8'h03) begin
                                wr_q <= 1'b0; state_q <= ADDR;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    ADDR: if (rise) begin
                        addr_sh_q  <= {addr_sh_q[aw-3:0], mosi_s2_q};
                        addr_cnt_q <= addr_cnt_q + 5'd1;
                        if (addr_cnt_q == 5'd23) begin
                            addr_q    <= {addr_sh_q, mosi_s2_q};
                            bit_cnt_q <= 3'd0;
                            if (wr_q) begin
                                state_q <= WDATA;
                            end else begin
                                re_q    <= 1'b1;
                                state_q <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        // Oversampling keeps the fetch cycle clear of any fall.
                        if (re_q) begin
                            tx_q <= ram.i_ram_rdata;
                        end else if (fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_q <= addr_inc;
                                re_q   <= 1'b1;
                            end
                        end
                    end
                    WDATA: if (rise) begin
                        rx_q      <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wdata_q <= rx_byte;
                            we_n_q  <= 1'b0;
                        end
                    end
                    IGNORE: miso_q <= 1'b0;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_miso          = miso_q;
    assign o_busy          = (state_q != IDLE);
    assign ram.o_ram_addr  = addr_q;
    assign ram.o_ram_wdata = wdata_q;
    assign ram.o_ram_we_n  = we_n_q;
    assign ram.o_ram_re    = re_q;
endmodule

// File: tb/tb_servant_spi_ram_ctrl.sv
module tb_servant_spi_ram_ctrl;
    localparam int AW     = 18;
    localparam int RAM_SZ = 1 << AW;
    localparam int MASK   = RAM_SZ - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, busy;

    servant_spi_ram_ctrl_if #(.aw(AW)) ram_if ();

    servant_spi_ram_ctrl #(.aw(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_busy(busy), .ram(ram_if)
    );

    always #5 clk = ~clk;

    // RAM array model
    logic [7:0] mem [RAM_SZ];
    assign ram_if.i_ram_rdata = mem[ram_if.o_ram_addr];
    always @(posedge clk) if (!ram_if.o_ram_we_n) mem[ram_if.o_ram_addr] <= ram_if.o_ram_wdata;

    // Reference memory: bytes written by the bench's own bookkeeping.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'hC3;
    endfunction
    function automatic logic [7:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    int n_tests = 0, n_fail = 0;
    int we_cnt, re_cnt, both_cnt, miso_hi;
    logic [25:0] wr_log [$];
    logic [17:0] re_log [$];
    logic [7:0]  wbuf [16];
    logic [7:0]  rbuf [16];

    always @(negedge clk) if (!rst) begin
        if (!ram_if.o_ram_we_n) begin
            wr_log.push_back({ram_if.o_ram_addr, ram_if.o_ram_wdata});
            we_cnt++;
        end
        if (ram_if.o_ram_re) begin
            re_log.push_back(ram_if.o_ram_addr);
            re_cnt++;
        end
        if (!ram_if.o_ram_we_n && ram_if.o_ram_re) both_cnt++;
        if (miso) miso_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        wr_log.delete(); re_log.delete();
        we_cnt = 0; re_cnt = 0; miso_hi = 0;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1; r = miso;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) spi_bit(t[i], r[i]);
    endtask

    task automatic cs_lo();
        cs_n = 1'b0; repeat (4) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (4) @(negedge clk); cs_n = 1'b1; repeat (6) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] r;
        spi_byte(cmd, r); spi_byte(a[23:16], r); spi_byte(a[15:8], r); spi_byte(a[7:0], r);
    endtask

    task automatic do_write(input logic [23:0] a, input int n, input string tag);
        logic [7:0] r;
        int ea;
        clr_logs();
        cs_lo(); send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) spi_byte(wbuf[i], r);
        cs_hi();
        chk($sformatf("%s_wr_count", tag), wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            ea = (int'(a) + i) & MASK;
            chk($sformatf("%s_wr_addr%0d", tag, i), 32'(wr_log[i][25:8]), ea);
            chk($sformatf("%s_wr_data%0d", tag, i), 32'(wr_log[i][7:0]), wbuf[i]);
        end
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) & MASK] = wbuf[i];
        chk($sformatf("%s_wr_no_re", tag), re_cnt, 0);
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        clr_logs();
        cs_lo(); send_hdr(8'h03, a);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rbuf[i]);
        cs_hi();
        chk($sformatf("%s_re_addr0", tag), re_log.size() > 0 ? 32'(re_log[0]) : 32'hDEAD,
            int'(a) & MASK);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_rd%0d", tag, i), rbuf[i], ref_rd((int'(a) + i) & MASK));
        chk($sformatf("%s_rd_no_we", tag), we_cnt, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [23:0] a;
        int n;
        for (int i = 0; i < RAM_SZ; i++) mem[i] = init_val(i);
        both_cnt = 0;
        clr_logs();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_addr", ram_if.o_ram_addr, 0);
        chk("rst_wdata", ram_if.o_ram_wdata, 0);
        chk("rst_we_n", ram_if.o_ram_we_n, 1);
        chk("rst_re", ram_if.o_ram_re, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Write then read back
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(24'h000010, 2, "wr10");
        do_read(24'h000010, 2, "rd10");
        chk("rd10_a5", rbuf[0], 8'hA5);
        chk("rd10_3c", rbuf[1], 8'h3C);

        // Wrap-around
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(24'h03FFFF, 2, "wrap");
        do_read(24'h03FFFF, 2, "rdwrap");
        chk("wrap_mem0", mem[0], 8'h22);

        // Abort mid-byte
        clr_logs();
        cs_lo(); send_hdr(8'h02, 24'h000020);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r[0]);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        chk("abort_no_we", we_cnt, 0);
        do_read(24'h000020, 1, "abort_rd");

        // Unknown command
        clr_logs();
        cs_lo(); spi_byte(8'h9F, r);
        for (int i = 0; i < 32; i++) spi_bit(1'($urandom), r[0]);
        chk("unk_busy_ignore", busy, 1);
        cs_hi();
        chk("unk_we", we_cnt, 0);
        chk("unk_re", re_cnt, 0);
        chk("unk_miso", miso_hi, 0);
        chk("unk_idle", busy, 0);

        // Async reset during RDATA
        cs_lo(); send_hdr(8'h03, 24'h000040);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r[0]);
        #2 rst = 1'b1;
        #1;
        chk("arst_miso", miso, 0);
        chk("arst_addr", ram_if.o_ram_addr, 0);
        chk("arst_we_n", ram_if.o_ram_we_n, 1);
        chk("arst_re", ram_if.o_ram_re, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_logs();
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom), r[0]);
        chk("arst_ign_busy", busy, 0);
        chk("arst_ign_re", re_cnt, 0);
        chk("arst_ign_we", we_cnt, 0);
        cs_hi();
        do_read(24'h000040, 2, "arst_rd");

        // Upper address bits dropped
        do_read(24'hFC0005, 1, "upper");

        // Randomized write/read-back against the reference memory
        for (int k = 0; k < 6; k++) begin
            a = 24'($urandom);
            if (k % 3 == 0) a[17:0] = 18'h3FFFF - 18'($urandom_range(0, 2));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n, $sformatf("rnd%0d_w", k));
            do_read(a, n, $sformatf("rnd%0d_r", k));
            a = 24'($urandom);
            do_read(a, 2, $sformatf("rnd%0d_x", k));
        end

        chk("strobe_excl", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
